// File: rtl/stream_demux_pkg.sv
// Shared constants and occupancy encodings for the 1-to-2 stream demultiplexer.
package stream_demux_pkg;

    localparam int DEMUX_DEPTH = 2;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_e;

endpackage

// File: rtl/demux_buffer.sv
// Two-entry FIFO for one demux output: occupancy FSM, head-word output and a
// wrapping count of words delivered to the consumer.
module demux_buffer
    import stream_demux_pkg::*;
#(
    parameter int size      = 8,
    parameter int cnt_width = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [size-1:0]      push_data,
    input  logic                 push_valid,
    output logic                 full,
    output logic [size-1:0]      out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [cnt_width-1:0] out_count
);

    localparam int PTR_W = (DEMUX_DEPTH > 1) ? $clog2(DEMUX_DEPTH) : 1;

    occ_e                 state_q, state_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [size-1:0]      mem_q [DEMUX_DEPTH];
    logic [size-1:0]      mem_d [DEMUX_DEPTH];
    logic [cnt_width-1:0] count_q, count_d;
    logic                 push;
    logic                 pop;

    // A full buffer refuses pushes even when it is being popped: no pass-through.
    assign full      = (state_q == TWO);
    assign out_valid = (state_q != EMPTY);
    assign push      = push_valid && !full;
    assign pop       = out_valid && out_ready;
    assign out_data  = mem_q[rd_ptr_q];
    assign out_count = count_q;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        count_d  = count_q;

        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            count_d  = count_q + 1'b1;
        end

        case (state_q)
            EMPTY: if (push) state_d = ONE;
            ONE: begin
                if (push && !pop)      state_d = TWO;
                else if (pop && !push) state_d = EMPTY;
            end
            TWO:     if (pop) state_d = ONE;
            default: state_d = EMPTY;
        endcase
    end

    // NOTE: non-blocking assignments for all state so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= EMPTY;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            // NOTE: storage is cleared on reset because out_data must read 0 after reset.
            for (int i = 0; i < DEMUX_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/stream_demux.sv
// Registered 1-to-2 stream demultiplexer: steers each accepted word to one of
// two independent 2-entry output buffers according to in_select.
module stream_demux
    import stream_demux_pkg::*;
#(
    parameter int size      = 8,
    parameter int cnt_width = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [size-1:0]      in_data,
    input  logic                 in_select,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [size-1:0]      out0_data,
    output logic                 out0_valid,
    input  logic                 out0_ready,
    output logic [cnt_width-1:0] out0_count,
    output logic [size-1:0]      out1_data,
    output logic                 out1_valid,
    input  logic                 out1_ready,
    output logic [cnt_width-1:0] out1_count
);

    logic full0;
    logic full1;

    // in_ready depends only on registered fullness, never on outN_ready.
    assign in_ready = in_select ? !full1 : !full0;

    demux_buffer #(.size(size), .cnt_width(cnt_width)) u_buf0 (
        .clk        (clk),
        .reset      (reset),
        .push_data  (in_data),
        .push_valid (in_valid && !in_select),
        .full       (full0),
        .out_data   (out0_data),
        .out_valid  (out0_valid),
        .out_ready  (out0_ready),
        .out_count  (out0_count)
    );

    demux_buffer #(.size(size), .cnt_width(cnt_width)) u_buf1 (
        .clk        (clk),
        .reset      (reset),
        .push_data  (in_data),
        .push_valid (in_valid && in_select),
        .full       (full1),
        .out_data   (out1_data),
        .out_valid  (out1_valid),
        .out_ready  (out1_ready),
        .out_count  (out1_count)
    );

endmodule
